// File: rtl/pipe_addsub.sv
// pipe_addsub -- skewed, chunked ripple add/subtract pipeline.
// Stage k adds operand slice k with the carry registered by stage k-1, so a
// result appears exactly STAGES = WIDTH/CHUNK cycles after it was accepted.
// All stages stall together when the output is held by the consumer.
// Optional feature: define PIPE_ADDSUB_SAT_EN to clamp signed overflow to the
// most positive / most negative value instead of wrapping.
module pipe_addsub #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = WIDTH / CHUNK;
   localparam int LAST   = STAGES - 1;

   // Stage registers: operands travel unchanged (b already conditioned for
   // subtract), the result fills in one slice per stage, carry links stages.
   logic             stageValid [STAGES];
   logic [WIDTH-1:0] stageA     [STAGES];
   logic [WIDTH-1:0] stageB     [STAGES];
   logic [WIDTH-1:0] stageRes   [STAGES];
   logic             stageCarry [STAGES];

   logic             nextValid  [STAGES];
   logic [WIDTH-1:0] nextA      [STAGES];
   logic [WIDTH-1:0] nextB      [STAGES];
   logic [WIDTH-1:0] nextRes    [STAGES];
   logic             nextCarry  [STAGES];

   logic [WIDTH-1:0] effB;
   logic             effCin;
   logic [CHUNK:0]   chunkSum;
   logic             advance;
   logic             msbA;
   logic             msbB;
   logic             msbRes;

   // One CHUNK-wide slice of the carry chain, returning {carry, slice sum}.
   function automatic logic [CHUNK:0] addSlice(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic             c,
                                                input int               k);
      return {1'b0, x[k*CHUNK +: CHUNK]} + {1'b0, y[k*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, c};
   endfunction

   // The whole pipe moves only when the output slot is empty or being taken.
   assign advance   = !stageValid[LAST] || out_ready;
   assign in_ready  = advance;
   assign out_valid = stageValid[LAST];

   // Next-state for every stage: stage 0 takes the inputs, the rest take the
   // previous stage and fill in their own result slice.
   always_comb begin
      effB     = sub ? ~b : b;
      effCin   = cin ^ sub;
      chunkSum = '0;
      for (int k = 0; k < STAGES; k++) begin
         nextValid[k] = 1'b0;
         nextA[k]     = '0;
         nextB[k]     = '0;
         nextRes[k]   = '0;
         nextCarry[k] = 1'b0;
      end

      chunkSum                = addSlice(a, effB, effCin, 0);
      nextValid[0]            = in_valid;
      nextA[0]                = a;
      nextB[0]                = effB;
      nextRes[0][CHUNK-1:0]   = chunkSum[CHUNK-1:0];
      nextCarry[0]            = chunkSum[CHUNK];

      for (int k = 1; k < STAGES; k++) begin
         chunkSum                     = addSlice(stageA[k-1], stageB[k-1],
                                                 stageCarry[k-1], k);
         nextValid[k]                 = stageValid[k-1];
         nextA[k]                     = stageA[k-1];
         nextB[k]                     = stageB[k-1];
         nextRes[k]                   = stageRes[k-1];
         nextRes[k][k*CHUNK +: CHUNK] = chunkSum[CHUNK-1:0];
         nextCarry[k]                 = chunkSum[CHUNK];
      end
   end

   // Stage registers: cleared on reset (discarding in-flight work), loaded
   // together on advance, otherwise frozen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            stageValid[k] <= 1'b0;
            stageA[k]     <= '0;
            stageB[k]     <= '0;
            stageRes[k]   <= '0;
            stageCarry[k] <= 1'b0;
         end
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            stageValid[k] <= nextValid[k];
            stageA[k]     <= nextA[k];
            stageB[k]     <= nextB[k];
            stageRes[k]   <= nextRes[k];
            stageCarry[k] <= nextCarry[k];
         end
      end
   end

   // Signed overflow: operands of equal sign producing a result of the other
   // sign, equivalent to carry-in XOR carry-out of the MSB.
   assign msbA   = stageA[LAST][WIDTH-1];
   assign msbB   = stageB[LAST][WIDTH-1];
   assign msbRes = stageRes[LAST][WIDTH-1];
   assign ovf    = (msbA == msbB) && (msbRes != msbA);
   assign cout   = stageCarry[LAST];

`ifdef PIPE_ADDSUB_SAT_EN
   // Clamp toward the sign of a when the full-width operation overflowed.
   always_comb begin
      sum = stageRes[LAST];
      if (ovf) begin
         sum = msbA ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   assign sum = stageRes[LAST];
`endif

endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub -- directed and random checks of pipe_addsub against an
// arithmetic reference model with a queue of in-flight results.
module tb_pipe_addsub;

   localparam int W      = 16;
   localparam int CH     = 4;
   localparam int STAGES = W / CH;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           age;
   } entry_t;

   entry_t       q[$];
   int           total = 0;
   int           bad   = 0;
   logic         prevStall = 1'b0;
   logic [W-1:0] prevSum;
   logic         prevCout;
   logic         prevOvf;

   pipe_addsub #(.WIDTH(W), .CHUNK(CH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a hung run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Plain integer arithmetic reference for one operation.
   function automatic entry_t refResult(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                        input logic icin, input logic isub);
      entry_t e;
      longint u;
      longint s;
      longint maxPos;
      longint minNeg;
      maxPos = (longint'(1) << (W - 1)) - 1;
      minNeg = -(longint'(1) << (W - 1));
      if (!isub) begin
         u      = longint'(ia) + longint'(ib) + longint'(icin);
         s      = longint'($signed(ia)) + longint'($signed(ib)) + longint'(icin);
         e.cout = (u >= (longint'(1) << W));
      end else begin
         u      = longint'(ia) - longint'(ib) - longint'(icin);
         s      = longint'($signed(ia)) - longint'($signed(ib)) - longint'(icin);
         e.cout = (u >= 0);
      end
      e.sum = u[W-1:0];
      e.ovf = (s > maxPos) || (s < minNeg);
`ifdef PIPE_ADDSUB_SAT_EN
      if (e.ovf) begin
         e.sum = ia[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
`endif
      e.age = 0;
      return e;
   endfunction

   task automatic checkWord(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic checkBit(input string tag, input logic got, input logic exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("[TB] FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   // Compare DUT outputs with the model for the coming edge, then advance the model.
   task automatic checkOutput(input logic ordy, output logic advanced);
      logic expValid;
      logic expReady;
      expValid = (q.size() > 0) && (q[0].age == STAGES);
      expReady = !expValid || ordy;
      checkBit("out_valid", out_valid, expValid);
      checkBit("in_ready", in_ready, expReady);
      if (expValid) begin
         checkWord("sum", sum, q[0].sum);
         checkBit("cout", cout, q[0].cout);
         checkBit("ovf", ovf, q[0].ovf);
      end
      if (prevStall) begin
         checkWord("stall_sum", sum, prevSum);
         checkBit("stall_cout", cout, prevCout);
         checkBit("stall_ovf", ovf, prevOvf);
      end
      prevStall = expValid && !ordy;
      prevSum   = sum;
      prevCout  = cout;
      prevOvf   = ovf;
      if (expValid && ordy) begin
         void'(q.pop_front());
      end
      if (expReady) begin
         foreach (q[i]) q[i].age++;
      end
      advanced = expReady;
   endtask

   // Drive one cycle of inputs at the falling edge, check, and step to the next falling edge.
   task automatic applyStimulus(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                                input logic icin, input logic isub, input logic ordy,
                                output logic accepted);
      logic   adv;
      entry_t e;
      in_valid  = iv;
      a         = ia;
      b         = ib;
      cin       = icin;
      sub       = isub;
      out_ready = ordy;
      #1;
      checkOutput(ordy, adv);
      accepted = iv && adv;
      if (accepted) begin
         e     = refResult(ia, ib, icin, isub);
         e.age = 1;
         q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic checkDrained(input string tag);
      total++;
      assert (q.size() == 0) else begin
         bad++;
         $error("[TB] FAIL %s pending=%0d required=0", tag, q.size());
      end
   endtask

   // Directed steps, backpressure, random traffic and mid-flight reset.
   initial begin
      logic         acc;
      logic [W-1:0] va [7];
      logic [W-1:0] vb [7];
      logic         vc [7];
      logic         vs [7];
      logic [W-1:0] corner [4];
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           idx;
      int           step;

      va = '{16'h1234, 16'h0005, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h8000};
      vb = '{16'h0FFF, 16'h0007, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h8000};
      vc = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      corner = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkBit("reset_out_valid", out_valid, 1'b0);
      checkBit("reset_in_ready", in_ready, 1'b1);
      checkWord("reset_sum", sum, '0);
      checkBit("reset_cout", cout, 1'b0);
      checkBit("reset_ovf", ovf, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] directed vectors");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, va[i], vb[i], vc[i], vs[i], 1'b1, acc);
      end
      repeat (8) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      checkDrained("directed_drain");

      $display("[TB] back-to-back with stall");
      idx  = 0;
      step = 0;
      while (idx < 8 && step < 50) begin
         applyStimulus(1'b1, W'(16'h1111 * (idx + 1)), W'(16'h0F0F + idx), idx[0], idx[1],
                       !(step >= 4 && step <= 6), acc);
         if (acc) idx++;
         step++;
      end
      repeat (10) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      checkDrained("stall_drain");

      $display("[TB] random traffic");
      for (int i = 0; i < 300; i++) begin
         ra = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
         rb = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
         applyStimulus($urandom_range(0, 3) != 0, ra, rb, 1'($urandom), 1'($urandom),
                       $urandom_range(0, 9) < 7, acc);
      end
      repeat (12) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      checkDrained("random_drain");

      $display("[TB] reset with work in flight");
      applyStimulus(1'b1, 16'h4321, 16'h1111, 1'b0, 1'b0, 1'b1, acc);
      applyStimulus(1'b1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b1, acc);
      applyStimulus(1'b1, 16'hABCD, 16'h0123, 1'b0, 1'b1, 1'b1, acc);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkBit("midreset_out_valid", out_valid, 1'b0);
      checkBit("midreset_in_ready", in_ready, 1'b1);
      checkWord("midreset_sum", sum, '0);
      checkBit("midreset_cout", cout, 1'b0);
      checkBit("midreset_ovf", ovf, 1'b0);
      q.delete();
      prevStall = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      applyStimulus(1'b1, 16'h1234, 16'h0FFF, 1'b1, 1'b0, 1'b1, acc);
      repeat (6) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      checkDrained("post_reset_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; SHALL be a multiple of CHUNK, minimum 4.
REQ-002 Parameter CHUNK, default 4: bits summed per pipeline stage; STAGES = WIDTH/CHUNK.
REQ-003 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1: reset is asynchronous and active-low.
REQ-005 in_valid  input  1: operand set presented.
REQ-006 in_ready  output  1: block accepts operand set this cycle.
REQ-007 a, b  input  WIDTH each: operands, two's complement.
REQ-008 cin  input  1: carry-in for add; borrow-in for subtract.
REQ-009 sub  input  1: 0 = a+b+cin, 1 = a-b-cin.
REQ-010 out_valid  output  1: result present.
REQ-011 out_ready  input  1: consumer accepts result this cycle.
REQ-012 sum  output  WIDTH: result.
REQ-013 cout  output  1: unsigned carry-out for add; NOT borrow for subtract (1 = no borrow).
REQ-014 ovf  output  1: signed overflow of the full-width operation.

Function
REQ-015 Transfer occurs on a cycle where valid and ready are both 1, on each side independently.
REQ-016 Subtract SHALL be computed as a + ~b + ~cin through the same carry chain.
REQ-017 Stage k (0..STAGES-1) SHALL add bit slice [k*CHUNK +: CHUNK] with the carry registered from stage k-1; stage 0 uses the effective carry-in.
REQ-018 Operand slices not yet consumed and result slices already produced SHALL travel in stage registers alongside the carry (skewed pipeline).
REQ-019 Latency SHALL be exactly STAGES cycles from input transfer to out_valid, absent backpressure; throughput one operation per cycle.
REQ-020 Each stage holds a valid bit; advance = !out_valid || out_ready; when advance is 0 all stages SHALL hold their contents.
REQ-021 in_ready SHALL equal advance (combinational from out_ready and out_valid only, never from in_valid).
REQ-022 sum, cout and ovf SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 ovf = carry into MSB XOR carry out of MSB of the final stage.
REQ-024 Bubbles (in_valid=0) SHALL propagate as invalid stages and never raise out_valid.
REQ-025 Simultaneous output transfer and input transfer in one cycle SHALL both complete with no loss or duplication.

Reset
REQ-026 On rst_n=0 all stage valid bits, out_valid, sum, cout, ovf SHALL go to 0 immediately; in_ready SHALL read 1 during reset.
REQ-027 Operations in flight at reset assertion SHALL be discarded; none SHALL appear after reset release.
REQ-028 First input transfer is allowed on the first rising edge with rst_n=1.

Configuration
REQ-029 Macro PIPE_ADDSUB_SAT_EN compiles in signed saturation.
REQ-030 With PIPE_ADDSUB_SAT_EN defined: when ovf=1, sum SHALL be the most positive value (0111..1) if operand a is non-negative, else the most negative value (1000..0); ovf still reports 1, cout unchanged.
REQ-031 Without PIPE_ADDSUB_SAT_EN: sum SHALL be the wrapped modulo-2^WIDTH result; no saturation logic present.

Verification (WIDTH=16, CHUNK=4, latency 4)
REQ-032 a=0x1234, b=0x0FFF, sub=0, cin=1, out_ready=1 -> 4 cycles later out_valid=1, sum=0x2234, cout=0, ovf=0.
REQ-033 a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF (0x8000 with SAT_EN), ovf=1, cout=1.
REQ-034 a=0xFFFF, b=0x0001, sub=0, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000 (0x7FFF with SAT_EN), ovf=1.
REQ-035 Back-to-back 8 inputs with out_ready low for cycles 5-7 -> in_ready low while stalled, all 8 results delivered in order, outputs stable during stall.
REQ-036 rst_n pulsed low with 3 operations in flight -> out_valid=0 at once, no stale results after release, next operation result after exactly 4 cycles.
